wb_stage: RTL and testbench

Writeback stage of the 5-stage RV32I pipeline. It sits between the memory stage and the register file.
- Accepts completed instructions from MEM over a valid/ready handshake and buffers up to two of them (output register plus skid register).
- Aligns and sign-extends load data, selects the writeback source, and drives the register-file write port.
- Exposes forwarding taps and a retired-instruction counter.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/wb_load_align.sv | 53 +++++
 rtl/wb_stage.sv | 146 ++++++++++++++
 tb/tb_wb_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: writeback source select, load funct3 values and
// default datapath widths used by the writeback stage.
package pipe_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_IMM  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment: picks the addressed byte/half out of the raw memory
// word, extends it, and flags misaligned or undefined load types.
module wb_load_align
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] raw_word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] load_data,
  output logic            load_exc
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = raw_word[7:0];
    case (addr_lo)
      2'd0: sel_byte = raw_word[7:0];
      2'd1: sel_byte = raw_word[15:8];
      2'd2: sel_byte = raw_word[23:16];
      2'd3: sel_byte = raw_word[31:24];
      default: sel_byte = raw_word[7:0];
    endcase
    sel_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
  end

  // Undefined funct3 values are treated as illegal loads rather than guessed at.
  always_comb begin
    load_data = '0;
    load_exc  = 1'b0;
    case (funct3)
      LD_B:  load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      LD_BU: load_data = {{(XLEN-8){1'b0}}, sel_byte};
      LD_H: begin
        load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
        load_exc  = addr_lo[0];
      end
      LD_HU: begin
        load_data = {{(XLEN-16){1'b0}}, sel_half};
        load_exc  = addr_lo[0];
      end
      LD_W: begin
        load_data = raw_word;
        load_exc  = (addr_lo != 2'b00);
      end
      default: load_exc = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: two-deep (output + skid) buffer between MEM and the
// register file, with forwarding taps and a retired-instruction counter.
module wb_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_funct3,
  input  logic [1:0]        mem_addr_lo,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [XLEN-1:0]   mem_load_data,
  input  logic [XLEN-1:0]   mem_pc,
  input  logic [XLEN-1:0]   mem_imm,
  input  logic              wb_stall,
  output logic              rf_write_en,
  output logic [REG_AW-1:0] rf_write_addr,
  output logic [XLEN-1:0]   rf_write_data,
  output logic              fwd0_valid,
  output logic [REG_AW-1:0] fwd0_rd,
  output logic [XLEN-1:0]   fwd0_data,
  output logic              fwd1_valid,
  output logic [REG_AW-1:0] fwd1_rd,
  output logic [XLEN-1:0]   fwd1_data,
  output logic              wb_load_exc,
  output logic [63:0]       instret
);

  logic [XLEN-1:0]   align_data;
  logic              align_exc;
  logic [XLEN-1:0]   in_data;
  logic              in_exc;

  logic              out_valid;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write;
  logic [XLEN-1:0]   out_data;
  logic              out_exc;

  logic              skid_valid;
  logic [REG_AW-1:0] skid_rd;
  logic              skid_reg_write;
  logic [XLEN-1:0]   skid_data;
  logic              skid_exc;

  logic              accept;
  logic              retire;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .raw_word  (mem_load_data),
    .funct3    (mem_funct3),
    .addr_lo   (mem_addr_lo),
    .load_data (align_data),
    .load_exc  (align_exc)
  );

  // The final writeback value is resolved before it is buffered, so both
  // buffer slots hold ready-to-write data for the forwarding taps.
  always_comb begin
    in_data = mem_alu_result;
    case (wb_sel_e'(mem_wb_sel))
      WB_SEL_ALU:  in_data = mem_alu_result;
      WB_SEL_LOAD: in_data = align_data;
      WB_SEL_PC4:  in_data = mem_pc + XLEN'(4);
      WB_SEL_IMM:  in_data = mem_imm;
      default:     in_data = mem_alu_result;
    endcase
    in_exc = (mem_wb_sel == WB_SEL_LOAD) && align_exc;
  end

  assign mem_ready = !skid_valid;
  assign accept    = mem_valid && mem_ready;
  assign retire    = out_valid && !wb_stall;

  // Output slot refills from skid first; a full skid blocks new accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_data      <= '0;
      out_exc       <= 1'b0;
    end else if (retire && skid_valid) begin
      out_valid     <= 1'b1;
      out_rd        <= skid_rd;
      out_reg_write <= skid_reg_write;
      out_data      <= skid_data;
      out_exc       <= skid_exc;
    end else if (accept && (!out_valid || retire)) begin
      out_valid     <= 1'b1;
      out_rd        <= mem_rd;
      out_reg_write <= mem_reg_write;
      out_data      <= in_data;
      out_exc       <= in_exc;
    end else if (retire) begin
      out_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid     <= 1'b0;
      skid_rd        <= '0;
      skid_reg_write <= 1'b0;
      skid_data      <= '0;
      skid_exc       <= 1'b0;
    end else if (retire && skid_valid) begin
      skid_valid     <= 1'b0;
    end else if (accept && out_valid && !retire) begin
      skid_valid     <= 1'b1;
      skid_rd        <= mem_rd;
      skid_reg_write <= mem_reg_write;
      skid_data      <= in_data;
      skid_exc       <= in_exc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if (retire && !out_exc) begin
      instret <= instret + 64'd1;
    end
  end

  // Write enable sees wb_stall directly so a held entry never writes twice.
  assign rf_write_en   = out_valid && out_reg_write && (out_rd != '0) && !out_exc && !wb_stall;
  assign rf_write_addr = out_rd;
  assign rf_write_data = out_data;
  assign wb_load_exc   = out_valid && out_exc;

  assign fwd0_valid = out_valid && out_reg_write && (out_rd != '0) && !out_exc;
  assign fwd0_rd    = out_rd;
  assign fwd0_data  = out_data;
  assign fwd1_valid = skid_valid && skid_reg_write && (skid_rd != '0) && !skid_exc;
  assign fwd1_rd    = skid_rd;
  assign fwd1_data  = skid_data;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [31:0] mem_pc;
  logic [31:0] mem_imm;
  logic        wb_stall;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        fwd0_valid;
  logic [4:0]  fwd0_rd;
  logic [31:0] fwd0_data;
  logic        fwd1_valid;
  logic [4:0]  fwd1_rd;
  logic [31:0] fwd1_data;
  logic        wb_load_exc;
  logic [63:0] instret;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic        writes;
  } entry_t;

  entry_t      modelQ[$];
  logic [63:0] modelInstret = 64'd0;

  wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_addr_lo    (mem_addr_lo),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_pc         (mem_pc),
    .mem_imm        (mem_imm),
    .wb_stall       (wb_stall),
    .rf_write_en    (rf_write_en),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .fwd0_valid     (fwd0_valid),
    .fwd0_rd        (fwd0_rd),
    .fwd0_data      (fwd0_data),
    .fwd1_valid     (fwd1_valid),
    .fwd1_rd        (fwd1_rd),
    .fwd1_data      (fwd1_data),
    .wb_load_exc    (wb_load_exc),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference result: the addressed bytes are shifted down and then masked or
  // extended by access size, independent of how the design selects them.
  function automatic void modelResult(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lo,
                                      input logic [31:0] alu, input logic [31:0] ld,
                                      input logic [31:0] pc, input logic [31:0] imm,
                                      output logic [31:0] data, output logic exc);
    int size;
    logic [31:0] shifted;
    data = 32'd0;
    exc  = 1'b0;
    case (sel)
      2'd0: data = alu;
      2'd2: data = pc + 32'd4;
      2'd3: data = imm;
      default: begin
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
        if (size == 0) exc = 1'b1;
        else exc = ((int'(lo) % size) != 0);
        shifted = ld >> (8 * int'(lo));
        if (size == 1) begin
          data = shifted & 32'hFF;
          if (f3 == 3'd0 && data >= 32'd128) data = data - 32'd256;
        end else if (size == 2) begin
          data = shifted & 32'hFFFF;
          if (f3 == 3'd1 && data >= 32'd32768) data = data - 32'd65536;
        end else begin
          data = ld;
        end
      end
    endcase
  endfunction

  // Reference model: an in-order queue of at most two completed instructions.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelQ.delete();
      modelInstret = 64'd0;
    end else begin
      bit     acc;
      entry_t e;
      acc = mem_valid && (modelQ.size() < 2);
      if (modelQ.size() > 0 && !wb_stall) begin
        if (!modelQ[0].exc) modelInstret = modelInstret + 64'd1;
        void'(modelQ.pop_front());
      end
      if (acc) begin
        modelResult(mem_wb_sel, mem_funct3, mem_addr_lo, mem_alu_result, mem_load_data,
                    mem_pc, mem_imm, e.data, e.exc);
        e.rd     = mem_rd;
        e.writes = mem_reg_write && (mem_rd != 5'd0) && !e.exc;
        modelQ.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    logic expEn, expF0, expF1, expExc;
    expEn  = (modelQ.size() > 0) && modelQ[0].writes && !wb_stall;
    expF0  = (modelQ.size() > 0) && modelQ[0].writes;
    expF1  = (modelQ.size() > 1) && modelQ[1].writes;
    expExc = (modelQ.size() > 0) && modelQ[0].exc;
    checkOutput("mem_ready", mem_ready, modelQ.size() < 2);
    checkOutput("rf_write_en", rf_write_en, expEn);
    if (expEn) begin
      checkOutput("rf_write_addr", rf_write_addr, modelQ[0].rd);
      checkOutput("rf_write_data", rf_write_data, modelQ[0].data);
    end
    checkOutput("wb_load_exc", wb_load_exc, expExc);
    checkOutput("fwd0_valid", fwd0_valid, expF0);
    if (expF0) begin
      checkOutput("fwd0_rd", fwd0_rd, modelQ[0].rd);
      checkOutput("fwd0_data", fwd0_data, modelQ[0].data);
    end
    checkOutput("fwd1_valid", fwd1_valid, expF1);
    if (expF1) begin
      checkOutput("fwd1_rd", fwd1_rd, modelQ[1].rd);
      checkOutput("fwd1_data", fwd1_data, modelQ[1].data);
    end
    checkOutput("instret", instret, modelInstret);
  end

  task automatic applyStimulus(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                               input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                               input logic [31:0] ld, input logic [31:0] pc, input logic [31:0] imm);
    mem_valid      = 1'b1;
    mem_rd         = rd;
    mem_reg_write  = rw;
    mem_wb_sel     = sel;
    mem_funct3     = f3;
    mem_addr_lo    = lo;
    mem_alu_result = alu;
    mem_load_data  = ld;
    mem_pc         = pc;
    mem_imm        = imm;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    wb_stall = 1'b0;
    applyStimulus(5'd0, 1'b0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    idle();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_rf_write_en", rf_write_en, 0);
    checkOutput("reset_fwd0_valid", fwd0_valid, 0);
    checkOutput("reset_mem_ready", mem_ready, 1);
    checkOutput("reset_instret", instret, 0);
    rst = 1'b0;

    // LB / LBU from the top byte
    applyStimulus(5'd5, 1'b1, 2'b01, 3'b000, 2'd3, 32'd0, 32'h80FF7F01, 32'd0, 32'd0);
    tick();
    checkOutput("lb_en", rf_write_en, 1);
    checkOutput("lb_addr", rf_write_addr, 5);
    checkOutput("lb_data", rf_write_data, 64'hFFFFFF80);
    applyStimulus(5'd5, 1'b1, 2'b01, 3'b100, 2'd3, 32'd0, 32'h80FF7F01, 32'd0, 32'd0);
    tick();
    checkOutput("lbu_data", rf_write_data, 64'h00000080);
    checkOutput("lbu_instret", instret, 1);
    idle();
    tick();
    checkOutput("lbu_retired", instret, 2);

    // Misaligned LW, then aligned LH from the upper half
    applyStimulus(5'd7, 1'b1, 2'b01, 3'b010, 2'd2, 32'd0, 32'h12345678, 32'd0, 32'd0);
    tick();
    checkOutput("lw_exc", wb_load_exc, 1);
    checkOutput("lw_en", rf_write_en, 0);
    applyStimulus(5'd8, 1'b1, 2'b01, 3'b001, 2'd2, 32'd0, 32'h80011234, 32'd0, 32'd0);
    tick();
    checkOutput("lw_instret", instret, 2);
    checkOutput("lh_data", rf_write_data, 64'hFFFF8001);
    checkOutput("lh_en", rf_write_en, 1);
    idle();
    tick();
    checkOutput("lh_instret", instret, 3);

    // Two ALU results held under stall, then drained in order
    wb_stall = 1'b1;
    applyStimulus(5'd1, 1'b1, 2'b00, 3'd0, 2'd0, 32'h11, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("stall_ready1", mem_ready, 1);
    applyStimulus(5'd2, 1'b1, 2'b00, 3'd0, 2'd0, 32'h22, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("stall_ready2", mem_ready, 0);
    checkOutput("stall_fwd0_rd", fwd0_rd, 1);
    checkOutput("stall_fwd0_data", fwd0_data, 64'h11);
    checkOutput("stall_fwd1_rd", fwd1_rd, 2);
    checkOutput("stall_fwd1_data", fwd1_data, 64'h22);
    checkOutput("stall_fwd1_valid", fwd1_valid, 1);
    checkOutput("stall_en", rf_write_en, 0);
    idle();
    tick();
    checkOutput("stall_en3", rf_write_en, 0);
    checkOutput("stall_instret", instret, 3);
    wb_stall = 1'b0;
    #1;
    checkOutput("drain1_en", rf_write_en, 1);
    checkOutput("drain1_addr", rf_write_addr, 1);
    checkOutput("drain1_data", rf_write_data, 64'h11);
    tick();
    checkOutput("drain2_en", rf_write_en, 1);
    checkOutput("drain2_addr", rf_write_addr, 2);
    checkOutput("drain2_data", rf_write_data, 64'h22);
    checkOutput("drain2_ready", mem_ready, 1);
    tick();
    checkOutput("drain_instret", instret, 5);

    // JAL link wrap, write to x0, LUI immediate
    applyStimulus(5'd1, 1'b1, 2'b10, 3'd0, 2'd0, 32'd0, 32'd0, 32'hFFFFFFFC, 32'd0);
    tick();
    checkOutput("jal_en", rf_write_en, 1);
    checkOutput("jal_data", rf_write_data, 64'h0);
    applyStimulus(5'd0, 1'b1, 2'b00, 3'd0, 2'd0, 32'h55, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("x0_en", rf_write_en, 0);
    checkOutput("x0_fwd0", fwd0_valid, 0);
    applyStimulus(5'd9, 1'b1, 2'b11, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'hABCDE000);
    tick();
    checkOutput("x0_instret", instret, 7);
    checkOutput("imm_data", rf_write_data, 64'hABCDE000);
    idle();
    tick();
    checkOutput("imm_instret", instret, 8);

    // Streaming with a short stall burst; the model checks every cycle
    for (int i = 0; i < 8; i++) begin
      wb_stall = (i == 3 || i == 4);
      applyStimulus(5'(10 + i), 1'b1, 2'b00, 3'd0, 2'd0, 32'(i * 32'h101), 32'd0, 32'd0, 32'd0);
      tick();
    end
    wb_stall = 1'b0;
    idle();
    repeat (3) tick();

    // Asynchronous reset with both slots full
    wb_stall = 1'b1;
    applyStimulus(5'd3, 1'b1, 2'b00, 3'd0, 2'd0, 32'h33, 32'd0, 32'd0, 32'd0);
    tick();
    applyStimulus(5'd4, 1'b1, 2'b00, 3'd0, 2'd0, 32'h44, 32'd0, 32'd0, 32'd0);
    tick();
    idle();
    checkOutput("full_ready", mem_ready, 0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_instret", instret, 0);
    checkOutput("arst_fwd0_valid", fwd0_valid, 0);
    checkOutput("arst_fwd1_valid", fwd1_valid, 0);
    checkOutput("arst_fwd1_rd", fwd1_rd, 0);
    checkOutput("arst_fwd1_data", fwd1_data, 0);
    checkOutput("arst_rf_addr", rf_write_addr, 0);
    checkOutput("arst_rf_data", rf_write_data, 0);
    checkOutput("arst_ready", mem_ready, 1);
    wb_stall = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    checkOutput("post_rst_en", rf_write_en, 0);
    checkOutput("post_rst_instret", instret, 0);
    checkOutput("post_rst_ready", mem_ready, 1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
